// File: rtl/fifo_pkg.sv
// Shared async-FIFO pointer definitions and Gray-code helpers, used by both the read and write domains.
package fifo_pkg;

    localparam int PTR_WIDTH    = 3;
    localparam int MAX_PTR_BITS = 32;

    typedef logic [PTR_WIDTH:0] ptr_t;

    function automatic logic [MAX_PTR_BITS-1:0] bin2gray(input logic [MAX_PTR_BITS-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Helpers work on a wide word so any pointer width up to 32 bits can zero-extend into them.
    function automatic logic [MAX_PTR_BITS-1:0] gray2bin(input logic [MAX_PTR_BITS-1:0] gray);
        logic [MAX_PTR_BITS-1:0] bin;
        bin[MAX_PTR_BITS-1] = gray[MAX_PTR_BITS-1];
        for (int i = MAX_PTR_BITS - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// Plain multi-flop synchronizer for a Gray-coded pointer crossing clock domains.
module ptr_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/read_handler.sv
// Read-domain pointer and flag logic of the dual-clock FIFO.
// Define READ_HANDLER_SYNC3_EN to use a three-stage write-pointer synchronizer instead of two.
module read_handler
    import fifo_pkg::*;
#(
    parameter int          PTR_WIDTH           = fifo_pkg::PTR_WIDTH,
    parameter int unsigned ALMOST_EMPTY_THRESH = 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [PTR_WIDTH:0] wr_ptr_gray,
    input  logic               rd_en,
    output logic               empty,
    output logic               almost_empty,
    output logic [PTR_WIDTH:0] rd_count,
    output logic               underflow,
    output logic [PTR_WIDTH-1:0] rd_addr,
    output logic [PTR_WIDTH:0] bin_rd_ptr,
    output logic [PTR_WIDTH:0] gray_rd_ptr
);

    localparam int PW = PTR_WIDTH + 1;

`ifdef READ_HANDLER_SYNC3_EN
    localparam int SYNC_STAGES = 3;
`else
    localparam int SYNC_STAGES = 2;
`endif

    logic [PTR_WIDTH:0] wr_gray_sync;
    logic [PTR_WIDTH:0] wr_bin_sync;
    logic               rd_fire;

    logic [PTR_WIDTH:0] bin_q, bin_d;
    logic [PTR_WIDTH:0] gray_q, gray_d;
    logic [PTR_WIDTH:0] cnt_q, cnt_d;
    logic               empty_q, empty_d;
    logic               almost_empty_q, almost_empty_d;
    logic               underflow_q, underflow_d;

    ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_wr_ptr_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (wr_ptr_gray),
        .q    (wr_gray_sync)
    );

    // Flags are computed from the post-read pointer so a read of the last entry empties on the same edge.
    always_comb begin
        rd_fire        = rd_en & ~empty_q;
        bin_d          = bin_q + {{PTR_WIDTH{1'b0}}, rd_fire};
        gray_d         = PW'(bin2gray(32'(bin_d)));
        wr_bin_sync    = PW'(gray2bin(32'(wr_gray_sync)));
        cnt_d          = wr_bin_sync - bin_d;
        empty_d        = (gray_d == wr_gray_sync);
        almost_empty_d = (32'(cnt_d) <= ALMOST_EMPTY_THRESH);
        underflow_d    = underflow_q | (rd_en & empty_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bin_q          <= '0;
            gray_q         <= '0;
            cnt_q          <= '0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            underflow_q    <= 1'b0;
        end else begin
            bin_q          <= bin_d;
            gray_q         <= gray_d;
            cnt_q          <= cnt_d;
            empty_q        <= empty_d;
            almost_empty_q <= almost_empty_d;
            underflow_q    <= underflow_d;
        end
    end

    assign empty        = empty_q;
    assign almost_empty = almost_empty_q;
    assign rd_count     = cnt_q;
    assign underflow    = underflow_q;
    assign bin_rd_ptr   = bin_q;
    assign gray_rd_ptr  = gray_q;
    assign rd_addr      = bin_q[PTR_WIDTH-1:0];

endmodule

// File: tb/tb_read_handler.sv
// Randomized self-checking bench for read_handler against an occupancy-level reference model.
module tb_read_handler;

`ifdef READ_HANDLER_SYNC3_EN
    localparam int STAGES = 3;
`else
    localparam int STAGES = 2;
`endif

    logic       clk;
    logic       rstn;
    logic [3:0] wr_ptr_gray;
    logic       rd_en;
    logic       empty;
    logic       almost_empty;
    logic [3:0] rd_count;
    logic       underflow;
    logic [2:0] rd_addr;
    logic [3:0] bin_rd_ptr;
    logic [3:0] gray_rd_ptr;

    int total;
    int bad;

    // Reference model: write and read positions as plain counters mod 16, plus a delay line of write positions.
    int wrBin;
    int rdModel;
    bit emptyM;
    bit uflowM;
    int cntM;
    int pipe[$];

    read_handler #(
        .PTR_WIDTH           (3),
        .ALMOST_EMPTY_THRESH (1)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .wr_ptr_gray  (wr_ptr_gray),
        .rd_en        (rd_en),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_count     (rd_count),
        .underflow    (underflow),
        .rd_addr      (rd_addr),
        .bin_rd_ptr   (bin_rd_ptr),
        .gray_rd_ptr  (gray_rd_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int toGray(input int v);
        return (v ^ (v >> 1)) & 15;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        wrBin   = 0;
        rdModel = 0;
        emptyM  = 1'b1;
        uflowM  = 1'b0;
        cntM    = 0;
        pipe.delete();
        for (int i = 0; i < STAGES; i++) pipe.push_back(0);
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".empty"}, 32'(empty), 32'(emptyM));
        checkOutput({tag, ".almost_empty"}, 32'(almost_empty), 32'(cntM <= 1));
        checkOutput({tag, ".rd_count"}, 32'(rd_count), 32'(cntM));
        checkOutput({tag, ".underflow"}, 32'(underflow), 32'(uflowM));
        checkOutput({tag, ".bin_rd_ptr"}, 32'(bin_rd_ptr), 32'(rdModel));
        checkOutput({tag, ".gray_rd_ptr"}, 32'(gray_rd_ptr), 32'(toGray(rdModel)));
        checkOutput({tag, ".rd_addr"}, 32'(rd_addr), 32'(rdModel % 8));
    endtask

    // Drive one clock of stimulus, advance the model across the edge, then compare everything.
    task automatic applyStimulus(input bit rd, input bit incWr, input string tag);
        int vis;
        if (incWr) wrBin = (wrBin + 1) % 16;
        rd_en       = rd;
        wr_ptr_gray = 4'(toGray(wrBin));
        @(posedge clk);
        if (rd && emptyM) uflowM = 1'b1;
        if (rd && !emptyM) rdModel = (rdModel + 1) % 16;
        vis = pipe.pop_front();
        pipe.push_back(wrBin);
        cntM   = (vis - rdModel + 16) % 16;
        emptyM = (cntM == 0);
        #1;
        checkAll(tag);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".empty"}, 32'(empty), 32'd1);
        checkOutput({tag, ".almost_empty"}, 32'(almost_empty), 32'd1);
        checkOutput({tag, ".rd_count"}, 32'(rd_count), 32'd0);
        checkOutput({tag, ".underflow"}, 32'(underflow), 32'd0);
        checkOutput({tag, ".bin_rd_ptr"}, 32'(bin_rd_ptr), 32'd0);
        checkOutput({tag, ".gray_rd_ptr"}, 32'(gray_rd_ptr), 32'd0);
    endtask

    // Enters with time just after a rising edge, leaves the same way with reset released.
    task automatic resetDut(input string tag);
        rstn        = 1'b0;
        rd_en       = 1'b1;
        wr_ptr_gray = 4'b0110;
        modelReset();
        #1;
        checkResetValues({tag, ".async"});
        repeat (2) @(posedge clk);
        #1;
        checkResetValues({tag, ".held"});
        rd_en       = 1'b0;
        wr_ptr_gray = 4'b0000;
        rstn        = 1'b1;
    endtask

    initial begin
        bit sawWrap;
        int prevBin;
        int occ;
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        rd_en = 1'b0;
        wr_ptr_gray = '0;
        modelReset();
        @(posedge clk);
        #1;
        resetDut("reset");

        // Single entry: visibility after STAGES edges, then a read of the last entry empties at once.
        applyStimulus(0, 1, "single.capture");
        for (int k = 1; k <= STAGES; k++) begin
            applyStimulus(0, 0, "single.wait");
            checkOutput("single.empty_latency", 32'(empty), 32'(k < STAGES));
        end
        checkOutput("single.count1", 32'(rd_count), 32'd1);
        checkOutput("single.ae1", 32'(almost_empty), 32'd1);
        applyStimulus(1, 0, "single.read");
        checkOutput("single.bin", 32'(bin_rd_ptr), 32'd1);
        checkOutput("single.gray", 32'(gray_rd_ptr), 32'b0001);
        checkOutput("single.empty_after", 32'(empty), 32'd1);
        checkOutput("single.count0", 32'(rd_count), 32'd0);

        // Full depth then drain with back-to-back reads.
        @(negedge clk);
        @(posedge clk);
        #1;
        resetDut("reset2");
        wrBin = 8;
        for (int k = 0; k <= STAGES; k++) applyStimulus(0, 0, "full.wait");
        checkOutput("full.count8", 32'(rd_count), 32'd8);
        checkOutput("full.ae0", 32'(almost_empty), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1, 0, "full.drain");
            checkOutput("full.drain_count", 32'(rd_count), 32'(8 - i));
            checkOutput("full.drain_ae", 32'(almost_empty), 32'((8 - i) <= 1));
            checkOutput("full.drain_empty", 32'(empty), 32'(i == 8));
        end
        checkOutput("full.bin8", 32'(bin_rd_ptr), 32'd8);
        checkOutput("full.gray", 32'(gray_rd_ptr), 32'b1100);
        checkOutput("full.addr", 32'(rd_addr), 32'd0);

        // Underflow: no pointer movement, sticky across later writes.
        applyStimulus(1, 0, "uflow.read");
        checkOutput("uflow.bin_hold", 32'(bin_rd_ptr), 32'd8);
        checkOutput("uflow.set", 32'(underflow), 32'd1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, "uflow.writes");
        for (int i = 0; i < STAGES; i++) applyStimulus(0, 0, "uflow.settle");
        checkOutput("uflow.sticky", 32'(underflow), 32'd1);

        // Lockstep writes and reads carry the read pointer through its wrap.
        sawWrap = 1'b0;
        prevBin = int'(bin_rd_ptr);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 1, "wrap");
            if (prevBin == 15 && int'(bin_rd_ptr) == 0) sawWrap = 1'b1;
            prevBin = int'(bin_rd_ptr);
        end
        checkOutput("wrap.seen", 32'(sawWrap), 32'd1);

        // Randomized traffic with a reset pulse in the middle.
        for (int i = 0; i < 600; i++) begin
            bit doRd;
            bit doWr;
            if (i == 300) begin
                #3;
                resetDut("midreset");
            end
            occ  = (wrBin - rdModel + 16) % 16;
            doRd = ($urandom_range(0, 99) < 50);
            doWr = ($urandom_range(0, 99) < 55) && (occ < 8);
            applyStimulus(doRd, doWr, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
